// File: rtl/inv_pipe_if.sv
// Stream + control bundle for inv_pipe.
// The producer/consumer environment uses the master view, the pipeline uses the slave view.
interface inv_pipe_if #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 16
);
   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   mask_in;
   logic               mask_load;
   logic [WIDTH-1:0]   mask;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [COUNT_W-1:0] xfer_count;

   modport master (
      output in_data, in_valid, mask_in, mask_load, out_ready,
      input  in_ready, mask, out_data, out_valid, xfer_count
   );

   modport slave (
      input  in_data, in_valid, mask_in, mask_load, out_ready,
      output in_ready, mask, out_data, out_valid, xfer_count
   );
endinterface

// File: rtl/inv_pipe.sv
// Polarity-mask pipeline: each word is XORed with the mask register on entry,
// then carried through DEPTH valid/ready register stages with full backpressure.
// A saturating counter tallies words handed to the consumer.
module inv_pipe #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 2,
   parameter int COUNT_W = 16
) (
   input logic       clk_i,
   input logic       rst_n_i,
   inv_pipe_if.slave bus
);

   logic [DEPTH-1:0]   valid_q;
   logic [DEPTH-1:0]   valid_d;
   logic [WIDTH-1:0]   data_q [DEPTH];
   logic [WIDTH-1:0]   data_d [DEPTH];
   logic [DEPTH-1:0]   stage_rdy;
   logic [WIDTH-1:0]   mask_q;
   logic [WIDTH-1:0]   mask_d;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;
   logic               out_xfer;

   // A stage may load when it, or any stage downstream of it, is empty, or the consumer takes the head.
   // Accumulated in a local so the chain is a clean ripple from out_ready, never from in_valid.
   always_comb begin
      logic acc;
      acc       = bus.out_ready;
      stage_rdy = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         acc          = acc | ~valid_q[k];
         stage_rdy[k] = acc;
      end
   end

   // Stage next-state: shift forward where allowed; data only moves with a valid source so an empty
   // last stage keeps presenting its previous word instead of garbage.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (stage_rdy[0]) begin
         valid_d[0] = bus.in_valid;
         if (bus.in_valid) begin
            data_d[0] = bus.in_data ^ mask_q;
         end
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (stage_rdy[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
   end

   // Mask and transfer-counter next-state; the counter sticks at all-ones.
   always_comb begin
      mask_d   = bus.mask_load ? bus.mask_in : mask_q;
      out_xfer = valid_q[DEPTH-1] & bus.out_ready;
      count_d  = count_q;
      if (out_xfer && (count_q != '1)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   // State registers; reset empties the pipe and restores plain inversion.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         data_q  <= '{default: '0};
         mask_q  <= '1;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         count_q <= count_d;
      end
   end

   assign bus.in_ready   = stage_rdy[0];
   assign bus.out_valid  = valid_q[DEPTH-1];
   assign bus.out_data   = data_q[DEPTH-1];
   assign bus.mask       = mask_q;
   assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_inv_pipe.sv
// Bench for inv_pipe: directed scenarios plus a randomized stall run, all checked cycle by
// cycle against a queue model (word, acceptance time) that applies the mask at acceptance.
module tb_inv_pipe;
   localparam int DEPTH = 2;

   typedef struct {
      logic [7:0] d;
      int         t;
   } ent_t;

   logic clk;
   logic rst_n;
   logic rst_sat;

   inv_pipe_if #(.WIDTH(8), .COUNT_W(16)) bus ();
   inv_pipe_if #(.WIDTH(8), .COUNT_W(4))  sat_bus ();

   inv_pipe #(.WIDTH(8), .DEPTH(DEPTH), .COUNT_W(16)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   inv_pipe #(.WIDTH(8), .DEPTH(DEPTH), .COUNT_W(4)) dut_sat (
      .clk_i   (clk),
      .rst_n_i (rst_sat),
      .bus     (sat_bus)
   );

   int         vectors;
   int         miscompares;
   ent_t       q[$];
   int         cyc;
   logic [7:0] mask_m;
   int         cnt_m;
   logic [7:0] obs[$];
   int         dut_acc_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // One clock cycle: drive, check against model, clock, advance model.
   task automatic step(input bit iv, input logic [7:0] id, input bit ordy,
                       input bit ml, input logic [7:0] mi, input bit rstn, output bit acc);
      bit exp_ov;
      bit exp_rdy;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      bus.mask_load = ml;
      bus.mask_in   = mi;
      rst_n         = rstn;
      #1;
      exp_ov  = (q.size() > 0) && ((cyc - q[0].t) >= DEPTH);
      exp_rdy = ordy || (q.size() < DEPTH);
      acc     = 1'b0;
      if (rstn) begin
         chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
         if (exp_ov) chk("out_data", 32'(bus.out_data), 32'(q[0].d));
         chk("mask", 32'(bus.mask), 32'(mask_m));
         chk("xfer_count", 32'(bus.xfer_count), 32'(cnt_m));
         if (bus.out_valid && ordy) obs.push_back(bus.out_data);
         if (iv && bus.in_ready) dut_acc_cnt++;
      end
      @(posedge clk);
      if (!rstn) begin
         q.delete();
         mask_m = 8'hFF;
         cnt_m  = 0;
      end else begin
         if (exp_ov && ordy) begin
            void'(q.pop_front());
            if (cnt_m != 65535) cnt_m++;
         end
         if (iv && exp_rdy) begin
            q.push_back('{d: id ^ mask_m, t: cyc});
            acc = 1'b1;
         end
         if (ml) mask_m = mi;
      end
      cyc++;
      #1;
   endtask

   initial begin
      bit         acc;
      bit         hold;
      bit         v;
      logic [7:0] d;
      int         w;
      int         sent;
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      mask_m      = 8'hFF;
      cnt_m       = 0;
      dut_acc_cnt = 0;
      rst_sat           = 1'b0;
      sat_bus.in_valid  = 1'b0;
      sat_bus.in_data   = 8'h00;
      sat_bus.out_ready = 1'b0;
      sat_bus.mask_load = 1'b0;
      sat_bus.mask_in   = 8'h00;

      // Power-up reset
      step(0, 8'h00, 0, 0, 8'h00, 0, acc);
      step(0, 8'h00, 0, 0, 8'h00, 0, acc);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'h00);
      chk("rst_mask", 32'(bus.mask), 32'hFF);
      chk("rst_count", 32'(bus.xfer_count), 32'd0);

      // Default mask, back-to-back
      obs.delete();
      step(1, 8'h00, 1, 0, 8'h00, 1, acc);
      step(1, 8'hA5, 1, 0, 8'h00, 1, acc);
      step(1, 8'hFF, 1, 0, 8'h00, 1, acc);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 8'h00, 1, acc);
      chk("t1_nwords", 32'(obs.size()), 32'd3);
      if (obs.size() == 3) begin
         chk("t1_w0", 32'(obs[0]), 32'hFF);
         chk("t1_w1", 32'(obs[1]), 32'h5A);
         chk("t1_w2", 32'(obs[2]), 32'h00);
      end
      chk("t1_count", 32'(bus.xfer_count), 32'd3);

      // Mask change coinciding with acceptance
      obs.delete();
      step(1, 8'h33, 1, 1, 8'h0F, 1, acc);
      step(1, 8'h33, 1, 0, 8'h00, 1, acc);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 8'h00, 1, acc);
      chk("t2_nwords", 32'(obs.size()), 32'd2);
      if (obs.size() == 2) begin
         chk("t2_w0", 32'(obs[0]), 32'hCC);
         chk("t2_w1", 32'(obs[1]), 32'h3C);
      end
      chk("t2_mask", 32'(bus.mask), 32'h0F);

      // Backpressure: only DEPTH words fit while the consumer stalls
      obs.delete();
      dut_acc_cnt = 0;
      w = 1;
      for (int i = 0; i < 5; i++) begin
         step(1, 8'(w), 0, 0, 8'h00, 1, acc);
         if (acc) w++;
      end
      chk("t3_accepted", 32'(dut_acc_cnt), 32'(DEPTH));
      chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_held", 32'(bus.out_data), 32'h0E);
      for (int i = 0; i < 12 && w <= 4; i++) begin
         step(1, 8'(w), 1, 0, 8'h00, 1, acc);
         if (acc) w++;
      end
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 8'h00, 1, acc);
      chk("t3_nwords", 32'(obs.size()), 32'd4);
      if (obs.size() == 4) begin
         chk("t3_w0", 32'(obs[0]), 32'h0E);
         chk("t3_w1", 32'(obs[1]), 32'h0D);
         chk("t3_w2", 32'(obs[2]), 32'h0C);
         chk("t3_w3", 32'(obs[3]), 32'h0B);
      end

      // Mid-operation reset with a full pipe and a freshly loaded mask
      step(1, 8'hAA, 0, 1, 8'h55, 1, acc);
      step(1, 8'hBB, 0, 0, 8'h00, 1, acc);
      step(1, 8'hCC, 0, 0, 8'h00, 1, acc);
      step(1, 8'hDD, 1, 1, 8'h12, 0, acc);
      chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_mask", 32'(bus.mask), 32'hFF);
      chk("t6_count", 32'(bus.xfer_count), 32'd0);
      obs.delete();
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 8'h00, 1, acc);
      chk("t6_no_stale", 32'(obs.size()), 32'd0);

      // Random stall run
      hold = 1'b0;
      v    = 1'b0;
      d    = 8'h00;
      sent = 0;
      for (int c = 0; c < 20000 && cnt_m < 1000; c++) begin
         if (!hold) begin
            v = (sent < 1000) && 1'($urandom_range(0, 1));
            d = 8'($urandom);
         end
         step(v, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 8'($urandom), 1, acc);
         if (acc) sent++;
         hold = v && !acc;
      end
      chk("t4_count", 32'(bus.xfer_count), 32'd1000);

      // Saturation on the COUNT_W=4 instance: word e accepted at edge e leaves at edge e+2
      for (int e = 0; e < 25; e++) begin
         sat_bus.in_valid  = (e < 20);
         sat_bus.in_data   = 8'(e);
         sat_bus.out_ready = 1'b1;
         rst_sat           = 1'b1;
         @(posedge clk);
         #1;
         chk("sat_count", 32'(sat_bus.xfer_count),
             32'((e < 2) ? 0 : ((e - 1) > 15 ? 15 : (e - 1))));
      end
      chk("sat_final", 32'(sat_bus.xfer_count), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
